// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 7-segment display between NREQ requesters.
// The winner's pattern is latched and shown for HOLD_CYCLES, then the winner gets a one-cycle ack.
module seg_display_arbiter #(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter logic [7:0]  IDLE_PATTERN = 8'b00000010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] pat,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        seg,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [7:0]       seg_q, seg_d;
  logic             busy_q, busy_d;

  logic             hit_hi, hit_lo;
  logic [PTR_W-1:0] w_hi, w_lo, w_sel;
  logic [7:0]       p_hi, p_lo, p_sel;

  // First set request at or above the pointer, else the first set request overall (wrap).
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    w_hi   = '0;
    w_lo   = '0;
    p_hi   = '0;
    p_lo   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (req[j] && !hit_hi && (PTR_W'(j) >= ptr_q)) begin
        hit_hi = 1'b1;
        w_hi   = PTR_W'(j);
        p_hi   = pat[8*j +: 8];
      end
      if (req[j] && !hit_lo) begin
        hit_lo = 1'b1;
        w_lo   = PTR_W'(j);
        p_lo   = pat[8*j +: 8];
      end
    end
    w_sel = hit_hi ? w_hi : w_lo;
    p_sel = hit_hi ? p_hi : p_lo;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    seg_d   = seg_q;
    busy_d  = busy_q;
    ack_d   = ena ? '0 : ack_q;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (hit_lo) begin
            state_d = ST_SHOW;
            win_d   = w_sel;
            grant_d = NREQ'(1) << w_sel;
            seg_d   = p_sel;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            busy_d  = 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == '0) begin
            state_d = ST_ACK;
            ack_d   = grant_q;
            grant_d = '0;
            seg_d   = IDLE_PATTERN;
            ptr_d   = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_ACK: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
          seg_d   = IDLE_PATTERN;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      seg_q   <= IDLE_PATTERN;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign ack   = ack_q;
  assign seg   = seg_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter (NREQ=3, HOLD_CYCLES=8, idle pattern 8'h02).
module tb_seg_display_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned HOLD = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] pat;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic [7:0]        seg;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  seg_display_arbiter #(
    .NREQ(NREQ),
    .HOLD_CYCLES(HOLD),
    .IDLE_PATTERN(8'b00000010)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .req(req),
    .pat(pat),
    .grant(grant),
    .ack(ack),
    .seg(seg),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; req = '0; pat = '0;
    step(); step();
    n_tests++;
    if ({seg, grant, ack, busy} !== {8'h02, 3'b000, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: seg=%h grant=%b ack=%b busy=%b required seg=02 grant=000 ack=000 busy=0",
               seg, grant, ack, busy);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      n_tests++;
      if ({seg, grant, ack, busy} !== {8'h02, 3'b000, 3'b000, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: seg=%h grant=%b ack=%b busy=%b required 02/000/000/0",
                 k, seg, grant, ack, busy);
      end
    end
  endtask

  task automatic test_single();
    req = 3'b001; pat[7:0] = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if ({seg, grant, ack, busy} !== {8'hFF, 3'b001, 3'b000, 1'b1}) begin
        n_fail++;
        $display("FAIL single_show[%0d]: seg=%h grant=%b ack=%b busy=%b required FF/001/000/1",
                 k, seg, grant, ack, busy);
      end
    end
    step();
    n_tests++;
    if ({seg, grant, ack, busy} !== {8'h02, 3'b000, 3'b001, 1'b1}) begin
      n_fail++;
      $display("FAIL single_ack: seg=%h grant=%b ack=%b busy=%b required 02/000/001/1",
               seg, grant, ack, busy);
    end
    req = '0;
    step();
    n_tests++;
    if ({seg, grant, ack, busy} !== {8'h02, 3'b000, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL single_idle: seg=%h grant=%b ack=%b busy=%b required 02/000/000/0",
               seg, grant, ack, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    logic [7:0] exp_p;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 3'b111; pat = {8'h04, 8'h02, 8'h01};
    for (int s = 0; s < 4; s++) begin
      exp_g = 3'b001 << (s % 3);
      exp_p = 8'h01 << (s % 3);
      for (int k = 1; k <= 8; k++) begin
        step();
        n_tests++;
        if ({seg, grant, ack} !== {exp_p, exp_g, 3'b000}) begin
          n_fail++;
          $display("FAIL rr_show[%0d.%0d]: seg=%h grant=%b ack=%b required %h/%b/000",
                   s, k, seg, grant, ack, exp_p, exp_g);
        end
      end
      step();
      n_tests++;
      if ({seg, grant, ack} !== {8'h02, 3'b000, exp_g}) begin
        n_fail++;
        $display("FAIL rr_ack[%0d]: seg=%h grant=%b ack=%b required 02/000/%b",
                 s, seg, grant, ack, exp_g);
      end
      if (s == 3) req = '0;
      step();
      n_tests++;
      if ({seg, grant, ack} !== {8'h02, 3'b000, 3'b000}) begin
        n_fail++;
        $display("FAIL rr_gap[%0d]: seg=%h grant=%b ack=%b required 02/000/000",
                 s, seg, grant, ack);
      end
    end
  endtask

  // Pointer is at requester 1 after the round-robin run.
  task automatic test_latch_drop();
    req = 3'b010; pat[15:8] = 8'h5A;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if ({seg, grant} !== {8'h5A, 3'b010}) begin
        n_fail++;
        $display("FAIL latch_show[%0d]: seg=%h grant=%b required 5A/010", k, seg, grant);
      end
      if (k == 3) begin
        pat[15:8] = 8'h33;
        req = '0;
      end
    end
    step();
    n_tests++;
    if ({seg, grant, ack} !== {8'h02, 3'b000, 3'b010}) begin
      n_fail++;
      $display("FAIL latch_ack: seg=%h grant=%b ack=%b required 02/000/010", seg, grant, ack);
    end
    step();
  endtask

  // Pointer is at requester 2 here.
  task automatic test_ena_freeze();
    req = 3'b100; pat[23:16] = 8'hC3;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_tests++;
      if ({seg, grant} !== {8'hC3, 3'b100}) begin
        n_fail++;
        $display("FAIL freeze_pre[%0d]: seg=%h grant=%b required C3/100", k, seg, grant);
      end
    end
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if ({seg, grant, ack, busy} !== {8'hC3, 3'b100, 3'b000, 1'b1}) begin
        n_fail++;
        $display("FAIL freeze_hold[%0d]: seg=%h grant=%b ack=%b busy=%b required C3/100/000/1",
                 k, seg, grant, ack, busy);
      end
    end
    ena = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++;
      if ({seg, grant} !== {8'hC3, 3'b100}) begin
        n_fail++;
        $display("FAIL freeze_post[%0d]: seg=%h grant=%b required C3/100", k, seg, grant);
      end
    end
    step();
    n_tests++;
    if ({seg, grant, ack} !== {8'h02, 3'b000, 3'b100}) begin
      n_fail++;
      $display("FAIL freeze_ack: seg=%h grant=%b ack=%b required 02/000/100", seg, grant, ack);
    end
    req = '0; ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (ack !== 3'b100) begin
        n_fail++;
        $display("FAIL ack_frozen[%0d]: ack=%b required 100", k, ack);
      end
    end
    ena = 1'b1;
    step();
    n_tests++;
    if ({ack, busy} !== {3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL ack_release: ack=%b busy=%b required 000/0", ack, busy);
    end
  endtask

  // Pointer is back at 0; only requester 2 asks, then reset hits mid-show.
  task automatic test_reset_mid();
    req = 3'b100; pat[23:16] = 8'h22; pat[7:0] = 8'h11;
    step();
    n_tests++;
    if (grant !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_grant: grant=%b required 100", grant);
    end
    step(); step();
    rst_n = 1'b0;
    step();
    n_tests++;
    if ({seg, grant, ack, busy} !== {8'h02, 3'b000, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: seg=%h grant=%b ack=%b busy=%b required 02/000/000/0",
               seg, grant, ack, busy);
    end
    rst_n = 1'b1; req = 3'b101;
    step();
    n_tests++;
    if ({seg, grant, ack} !== {8'h11, 3'b001, 3'b000}) begin
      n_fail++;
      $display("FAIL mid_rearb: seg=%h grant=%b ack=%b required 11/001/000", seg, grant, ack);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_latch_drop();
    test_ena_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
